// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared mode encodings and width helper for the LED pattern sequencer
package led_seq_pkg;

    localparam logic [1:0] MODE_ROTATE = 2'd0;
    localparam logic [1:0] MODE_BOUNCE = 2'd1;
    localparam logic [1:0] MODE_BAR    = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    // Counter width able to hold (div_n << 3) - 1, the longest step period.
    function automatic int cnt_width(input int div_n);
        longint unsigned max_period;
        max_period = longint'(div_n) << 3;
        return (max_period > 1) ? $clog2(max_period) : 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - step prescaler producing one tick every DIV_N << speed enabled cycles
module tick_gen
    import led_seq_pkg::*;
#(
    parameter int DIV_N = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] speed,
    output logic       tick
);

    localparam int CW = cnt_width(DIV_N);

    localparam logic [CW-1:0] TERM0 = CW'(DIV_N - 1);
    localparam logic [CW-1:0] TERM1 = CW'(DIV_N * 2 - 1);
    localparam logic [CW-1:0] TERM2 = CW'(DIV_N * 4 - 1);
    localparam logic [CW-1:0] TERM3 = CW'(DIV_N * 8 - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    speed_q;
    logic [1:0]    speed_eff;
    logic [CW-1:0] term;

    // A new period samples the live speed; mid-period the latched one is kept,
    // so a speed change lands at the next wrap without clearing the count.
    assign speed_eff = (cnt == '0) ? speed : speed_q;

    // Terminal count for the period in progress.
    always_comb begin
        term = TERM0;
        case (speed_eff)
            2'd0: term = TERM0;
            2'd1: term = TERM1;
            2'd2: term = TERM2;
            2'd3: term = TERM3;
            default: term = TERM0;
        endcase
    end

    assign tick = en && (cnt == term);

    // Count enabled cycles, wrapping to zero on the terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            speed_q <= 2'd0;
        end else if (en) begin
            speed_q <= speed_eff;
            cnt     <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_pattern_seq.sv
// rtl/led_pattern_seq.sv - LED pattern sequencer: rotate, bounce, bar and blink patterns
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int SIM   = 0,
    parameter int N_LED = 8,
    parameter int DIV_N = (SIM != 0) ? 10 : 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             direction,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    output logic [N_LED-1:0] led,
    output logic             step_pulse
);

    localparam int PW = (N_LED > 1) ? $clog2(N_LED) : 1;
    localparam logic [PW-1:0] POS_LAST = PW'(N_LED - 1);
    localparam logic [PW-1:0] POS_PRE  = PW'(N_LED - 2);

    logic          tick;
    logic [PW-1:0] pos;
    logic [PW-1:0] pos_nxt;
    logic          bdir;
    logic          bdir_nxt;
    logic [1:0]    mode_q;
    logic          dir_q;
    logic          mode_chg;

    tick_gen #(
        .DIV_N (DIV_N)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .speed (speed),
        .tick  (tick)
    );

    assign step_pulse = tick & en;
    assign mode_chg   = (mode != mode_q);

    // Next pattern position for one step in the current mode.
    always_comb begin
        pos_nxt  = pos;
        bdir_nxt = bdir;
        case (mode_q)
            MODE_ROTATE: begin
                if (direction)
                    pos_nxt = (pos == POS_LAST) ? '0 : pos + PW'(1);
                else
                    pos_nxt = (pos == '0) ? POS_LAST : pos - PW'(1);
            end
            MODE_BOUNCE: begin
                if (bdir) begin
                    if (pos == POS_LAST) begin
                        bdir_nxt = 1'b0;
                        pos_nxt  = POS_PRE;
                    end else begin
                        pos_nxt = pos + PW'(1);
                    end
                end else begin
                    if (pos == '0) begin
                        bdir_nxt = 1'b1;
                        pos_nxt  = PW'(1);
                    end else begin
                        pos_nxt = pos - PW'(1);
                    end
                end
            end
            MODE_BAR: pos_nxt = (pos == POS_LAST) ? '0 : pos + PW'(1);
            MODE_BLINK: pos_nxt = pos[0] ? '0 : PW'(1);
            default: pos_nxt = pos;
        endcase
    end

    // Pattern state; a mode change restarts the pattern and outranks a step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos    <= '0;
            bdir   <= 1'b1;
            mode_q <= MODE_ROTATE;
            dir_q  <= 1'b1;
        end else if (en) begin
            if (mode_chg) begin
                pos    <= '0;
                bdir   <= 1'b1;
                mode_q <= mode;
                dir_q  <= direction;
            end else if (step_pulse) begin
                pos   <= pos_nxt;
                bdir  <= bdir_nxt;
                dir_q <= direction;
            end
        end
    end

    // Output decode from registered state only, so led never glitches on inputs.
    always_comb begin
        led = '0;
        case (mode_q)
            MODE_ROTATE, MODE_BOUNCE: led[pos] = 1'b1;
            MODE_BAR: begin
                for (int i = 0; i < N_LED; i++)
                    led[i] = dir_q ? (i <= int'(pos)) : (i >= N_LED - 1 - int'(pos));
            end
            MODE_BLINK: begin
                for (int i = 0; i < N_LED; i++)
                    led[i] = ((i % 2) == 0) ^ pos[0];
            end
            default: led = '0;
        endcase
    end

endmodule

// File: tb/tb_led_pattern_seq.sv
// tb/tb_led_pattern_seq.sv - scoreboard bench for led_pattern_seq against a behavioural model
module tb_led_pattern_seq;

    localparam int N   = 8;
    localparam int DIV = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic         direction = 1'b1;
    logic [1:0]   mode = 2'd0;
    logic [1:0]   speed = 2'd0;
    logic [N-1:0] led;
    logic         step_pulse;

    always #5 clk = ~clk;

    led_pattern_seq #(
        .SIM   (1),
        .N_LED (N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .direction  (direction),
        .mode       (mode),
        .speed      (speed),
        .led        (led),
        .step_pulse (step_pulse)
    );

    typedef struct {
        logic [N-1:0] led;
        logic         step;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: elapsed cycles in the current period, that period's
    // length, and an abstract pattern index k (bounce uses a 0..2N-3 phase).
    int elapsed, per_cur, k, mode_m;
    bit dir_m;

    function automatic void model_reset();
        elapsed = 0;
        per_cur = DIV;
        k       = 0;
        mode_m  = 0;
        dir_m   = 1'b1;
    endfunction

    function automatic logic [N-1:0] model_led();
        logic [63:0] v;
        int          p;
        v = '0;
        case (mode_m)
            0: v = 64'd1 << k;
            1: begin
                p = (k < N) ? k : (2 * N - 2 - k);
                v = 64'd1 << p;
            end
            2: begin
                v = (64'd1 << (k + 1)) - 64'd1;
                if (!dir_m) v = v << (N - 1 - k);
            end
            default: begin
                for (int i = 0; i < N; i += 2) v[i] = 1'b1;
                if ((k % 2) == 1) v = ~v;
            end
        endcase
        return v[N-1:0];
    endfunction

    task automatic cycle(input bit r, input bit e, input bit d, input int m, input int s);
        int per_eff;
        bit tk;
        @(negedge clk);
        reset = r; en = e; direction = d; mode = m[1:0]; speed = s[1:0];
        if (r) begin
            model_reset();
            sb.push_back('{led: model_led(), step: 1'b0});
        end else begin
            per_eff = (elapsed == 0) ? (DIV << s) : per_cur;
            tk = e && (elapsed == per_eff - 1);
            sb.push_back('{led: model_led(), step: tk});
            if (e) begin
                per_cur = per_eff;
                elapsed = tk ? 0 : elapsed + 1;
                if (m != mode_m) begin
                    mode_m = m;
                    k      = 0;
                    dir_m  = d;
                end else if (tk) begin
                    dir_m = d;
                    case (mode_m)
                        0: k = d ? (k + 1) % N : (k + N - 1) % N;
                        1: k = (k + 1) % (2 * N - 2);
                        2: k = (k + 1) % N;
                        default: k = k ^ 1;
                    endcase
                end
            end
        end
    endtask

    // Monitor: outputs are presented every cycle; compare just after the driving edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checks++;
                if (led !== x.led) begin
                    errors++;
                    $display("FAIL led t=%0t got %h expected %h", $time, led, x.led);
                end
                checks++;
                if (step_pulse !== x.step) begin
                    errors++;
                    $display("FAIL step_pulse t=%0t got %b expected %b", $time, step_pulse, x.step);
                end
            end
        end
    end

    initial begin
        bit ce, cd, cr;
        int cm, cs, rst_hold;
        model_reset();

        // Reset state
        repeat (3) cycle(1, 1, 1, 0, 0);

        // Rotate up, speed 0
        repeat (100) cycle(0, 1, 1, 0, 0);

        // Freeze mid-count, then resume
        repeat (4) cycle(0, 1, 1, 0, 0);
        repeat (25) cycle(0, 0, 0, 0, 3);
        repeat (30) cycle(0, 1, 1, 0, 0);

        // Bounce from reset
        cycle(1, 1, 1, 1, 0);
        repeat (170) cycle(0, 1, 1, 1, 0);

        // Bar, downward, speed 1
        cycle(1, 1, 0, 2, 1);
        repeat (200) cycle(0, 1, 0, 2, 1);

        // Rotate to 08 then switch to blink on the tick cycle
        cycle(1, 1, 1, 0, 0);
        repeat (39) cycle(0, 1, 1, 0, 0);
        repeat (40) cycle(0, 1, 1, 3, 0);

        // Asynchronous reset while rotating, then recovery
        cycle(1, 1, 1, 0, 0);
        repeat (55) cycle(0, 1, 1, 0, 0);
        cycle(1, 1, 1, 0, 0);
        repeat (25) cycle(0, 1, 1, 0, 0);

        // Randomized operation
        ce = 1; cd = 1; cm = 0; cs = 0; rst_hold = 0;
        for (int n = 0; n < 15000; n++) begin
            if (ce) begin
                if ($urandom_range(0, 39) == 0) ce = 0;
            end else if ($urandom_range(0, 3) == 0) ce = 1;
            if ($urandom_range(0, 59) == 0) cd = ~cd;
            if ($urandom_range(0, 299) == 0) cm = $urandom_range(0, 3);
            if ($urandom_range(0, 199) == 0) cs = $urandom_range(0, 3);
            if (rst_hold == 0 && $urandom_range(0, 2499) == 0) rst_hold = $urandom_range(1, 2);
            cr = (rst_hold > 0);
            if (rst_hold > 0) rst_hold--;
            cycle(cr, ce, cd, cm, cs);
        end

        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_seq.md
LED_PATTERN_SEQ -- requirements
Module: led_pattern_seq

Interface
REQ-001 Parameter SIM, default 0; 1 selects the simulation divisor.
REQ-002 Parameter N_LED, default 8; LED count, legal range 2..32.
REQ-003 Parameter DIV_N, default SIM ? 10 : 50_000_000; base clock cycles per step.
REQ-004 Port clk  in  1  single system clock; all state updates on the rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Port en  in  1  when 1, run; when 0, freeze the prescaler and the pattern.
REQ-007 Port direction  in  1  1 = up (index increasing), 0 = down.
REQ-008 Port mode  in  2  0 ROTATE, 1 BOUNCE, 2 BAR, 3 BLINK.
REQ-009 Port speed  in  2  step period = DIV_N << speed clk cycles.
REQ-010 Port led  out  N_LED  pattern output, decoded from registered state only.
REQ-011 Port step_pulse  out  1  one-cycle strobe on every cycle the pattern state advances.

Function
REQ-012 The prescaler SHALL count 0..(DIV_N<<speed)-1 while en=1, and SHALL assert the internal tick on terminal count, then wrap to 0.
REQ-013 A change of speed SHALL take effect at the next prescaler wrap; the count SHALL not be cleared.
REQ-014 While en=0, the prescaler, pos, bdir and led SHALL hold, and step_pulse SHALL be 0.
REQ-015 State SHALL be pos (clog2(N_LED) bits), bdir (1 = up) and mode_q (registered mode).
REQ-016 step_pulse SHALL equal tick AND en; pos and bdir SHALL update on that same edge, and led SHALL show the new value in the following cycle.
REQ-017 ROTATE: led = onehot(pos); on step, pos+1 if direction=1, else pos-1; wrap N_LED-1<->0.
REQ-018 BOUNCE: led = onehot(pos); direction input ignored; on step with bdir=1, pos+1, except at pos=N_LED-1, where bdir<=0 and pos<=N_LED-2; mirror rule at pos=0.
REQ-019 BAR, direction=1: led bits [pos:0] = 1; direction=0: led bits [N_LED-1:N_LED-1-pos] = 1; on step, pos+1, wrap N_LED-1->0.
REQ-020 BLINK: led = alternating 1010... pattern with bit0=1 when pos[0]=0, and the bitwise inverse when pos[0]=1; on step, pos toggles between 0 and 1.
REQ-021 When mode != mode_q, the block SHALL set pos<=0, bdir<=1 and mode_q<=mode on that edge, with priority over a simultaneous step; step_pulse SHALL still pulse, and the prescaler SHALL be unaffected.
REQ-022 A direction change in ROTATE or BAR SHALL apply at the next step without clearing pos.
REQ-023 led SHALL be glitch-free: it is driven only from pos and mode_q, plus registered direction.

Reset
REQ-024 While reset=1: prescaler=0, pos=0, bdir=1, mode_q=0, led=onehot(0)=...0001, step_pulse=0.
REQ-025 Reset asserted mid-step SHALL abort immediately; the first step after release SHALL occur exactly DIV_N<<speed cycles after the first enabled cycle.

Structure
REQ-026 The mode encodings (MODE_ROTATE/BOUNCE/BAR/BLINK) SHALL live in the shared package led_seq_pkg, with the helper function for counter-width computation.
REQ-027 The prescaler SHALL be a separate sub-module, tick_gen, with ports clk, reset, en, speed and tick; pattern state and decode SHALL stay in led_pattern_seq.

Verification (SIM=1, DIV_N=10, N_LED=8)
REQ-028 Reset release, en=1, mode=0, direction=1, speed=0 -> step_pulse every 10 clks; led 01,02,04,...,80,01.
REQ-029 mode=1 from reset, 16 steps -> led 01,02,...,80,40,...,01,02; one cycle of 80 and of 01 at each turn.
REQ-030 mode=2, direction=0, speed=1 -> steps every 20 clks; led 80,C0,E0,...,FF,80.
REQ-031 ROTATE at led=08, mode switched to 3 in the same cycle as a tick -> next led 55, then AA, 55 every 10 clks.
REQ-032 en=0 for 25 clks mid-count at count 4 -> led held, no step_pulse; after en=1, the next step comes 6 clks later.
REQ-033 reset pulsed at led=20 -> led=01 asynchronously, before the next clk edge; first step 10 clks after release.
